// File: rtl/uart_frame_pkg.sv
// Shared state encoding and constants for the UART frame controller and its payload buffer.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_HOLD
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         ERR_CNT_W         = 8;

  // Saturating increment for the error counter.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload register file: one synchronous write port and one asynchronous read port.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  // Contents are deliberately not reset; only a checked frame is ever exposed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = (32'(rd_addr) < 32'(DEPTH)) ? mem[rd_addr] : 8'h00;

endmodule

// File: rtl/uart_frame_ctrl.sv
// Assembles SYNC/CMD/LEN/payload/CHK frames from a UART byte stream and holds each checked
// frame until consumed. Define UART_FRAME_TIMEOUT_EN to enable the inter-byte timeout.
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int          MAX_LEN      = 16,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int          TIMEOUT_CLKS = 52080,
  localparam int         LEN_W        = $clog2(MAX_LEN + 1),
  localparam int         IDX_W        = $clog2(MAX_LEN)
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_RX_DV,
  input  logic [7:0]           i_RX_Byte,
  output logic                 o_Frame_Valid,
  input  logic                 i_Frame_Ready,
  output logic [7:0]           o_Frame_Cmd,
  output logic [LEN_W-1:0]     o_Frame_Len,
  input  logic [IDX_W-1:0]     i_Rd_Addr,
  output logic [7:0]           o_Rd_Data,
  output logic                 o_Busy,
  output logic                 o_Err_Chk,
  output logic                 o_Err_Len,
  output logic                 o_Err_Timeout,
  output logic                 o_Drop,
  output logic [ERR_CNT_W-1:0] o_Err_Count
);

  state_t               state_reg;
  logic                 busy_reg;
  logic                 valid_reg;
  logic                 err_chk_reg;
  logic                 err_len_reg;
  logic                 err_timeout_reg;
  logic                 drop_reg;
  logic [7:0]           cmd_reg;
  logic [7:0]           chk_reg;
  logic [LEN_W-1:0]     len_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [ERR_CNT_W-1:0] err_count_reg;

  logic       in_frame;
  logic       len_too_big;
  logic       last_payload;
  logic       timeout_hit;
  logic       buf_we;
  logic [7:0] buf_rd_data;

  assign in_frame     = (state_reg == ST_CMD) || (state_reg == ST_LEN) ||
                        (state_reg == ST_PAYLOAD) || (state_reg == ST_CHK);
  assign len_too_big  = 32'(i_RX_Byte) > 32'(MAX_LEN);
  assign last_payload = (LEN_W'(idx_reg) == (len_reg - LEN_W'(1)));
  assign buf_we       = (state_reg == ST_PAYLOAD) && i_RX_DV;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CLKS);

  logic [TO_W-1:0] timeout_cnt_reg;

  always_ff @(posedge i_Clock) begin
    if (i_Reset || i_RX_DV || !in_frame) begin
      timeout_cnt_reg <= '0;
    end else begin
      timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
    end
  end

  // Fires on the edge TIMEOUT_CLKS-1 clocks after the last accepted strobe; a byte on that edge wins.
  assign timeout_hit = in_frame && !i_RX_DV && (timeout_cnt_reg == TO_W'(TIMEOUT_CLKS - 2));
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^32'(TIMEOUT_CLKS);
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_reg       <= ST_IDLE;
      busy_reg        <= 1'b0;
      valid_reg       <= 1'b0;
      err_chk_reg     <= 1'b0;
      err_len_reg     <= 1'b0;
      err_timeout_reg <= 1'b0;
      drop_reg        <= 1'b0;
      cmd_reg         <= 8'h00;
      chk_reg         <= 8'h00;
      len_reg         <= '0;
      idx_reg         <= '0;
      err_count_reg   <= '0;
    end else begin
      err_chk_reg     <= 1'b0;
      err_len_reg     <= 1'b0;
      err_timeout_reg <= 1'b0;
      drop_reg        <= 1'b0;

      if (timeout_hit) begin
        state_reg       <= ST_IDLE;
        busy_reg        <= 1'b0;
        err_timeout_reg <= 1'b1;
        err_count_reg   <= sat_inc(err_count_reg);
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) begin
              state_reg <= ST_CMD;
              busy_reg  <= 1'b1;
            end
          end

          ST_CMD: begin
            if (i_RX_DV) begin
              cmd_reg   <= i_RX_Byte;
              chk_reg   <= i_RX_Byte;
              state_reg <= ST_LEN;
            end
          end

          ST_LEN: begin
            if (i_RX_DV) begin
              if (len_too_big) begin
                state_reg     <= ST_IDLE;
                busy_reg      <= 1'b0;
                err_len_reg   <= 1'b1;
                err_count_reg <= sat_inc(err_count_reg);
              end else begin
                len_reg   <= i_RX_Byte[LEN_W-1:0];
                chk_reg   <= chk_reg ^ i_RX_Byte;
                idx_reg   <= '0;
                state_reg <= (i_RX_Byte == 8'h00) ? ST_CHK : ST_PAYLOAD;
              end
            end
          end

          ST_PAYLOAD: begin
            if (i_RX_DV) begin
              chk_reg <= chk_reg ^ i_RX_Byte;
              // idx stops at LEN-1 so it never wraps even when LEN == MAX_LEN.
              if (last_payload) begin
                state_reg <= ST_CHK;
              end else begin
                idx_reg <= idx_reg + 1'b1;
              end
            end
          end

          ST_CHK: begin
            if (i_RX_DV) begin
              if (i_RX_Byte == chk_reg) begin
                state_reg <= ST_HOLD;
                valid_reg <= 1'b1;
              end else begin
                state_reg     <= ST_IDLE;
                busy_reg      <= 1'b0;
                err_chk_reg   <= 1'b1;
                err_count_reg <= sat_inc(err_count_reg);
              end
            end
          end

          ST_HOLD: begin
            if (i_RX_DV) begin
              drop_reg <= 1'b1;
            end
            if (i_Frame_Ready) begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
              valid_reg <= 1'b0;
            end
          end

          default: begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (IDX_W)
  ) u_buf (
    .clk     (i_Clock),
    .we      (buf_we),
    .wr_addr (idx_reg),
    .wr_data (i_RX_Byte),
    .rd_addr (i_Rd_Addr),
    .rd_data (buf_rd_data)
  );

  assign o_Frame_Valid = valid_reg;
  assign o_Frame_Cmd   = cmd_reg;
  assign o_Frame_Len   = len_reg;
  // Buffer contents are undefined after reset, so the read port is masked outside HOLD.
  assign o_Rd_Data     = valid_reg ? buf_rd_data : 8'h00;
  assign o_Busy        = busy_reg;
  assign o_Err_Chk     = err_chk_reg;
  assign o_Err_Len     = err_len_reg;
  assign o_Err_Timeout = err_timeout_reg;
  assign o_Drop        = drop_reg;
  assign o_Err_Count   = err_count_reg;

endmodule
